// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared register-file widths and writeback entry type
// Purpose: common constants for the register-file writeback path.
//   REG_ADDR_W / REG_DATA_W : register index and data widths
//   REG_ZERO                : hard-wired zero register index
//   wb_entry_t              : one queued writeback {reg_idx, data}
package mips_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] reg_idx;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/mips_reg_writeback_queue_if.sv
// rtl/mips_reg_writeback_queue_if.sv - writeback queue bus bundle
// Purpose: groups the request handshake, register-file write port,
// forwarding lookups and occupancy of the writeback queue.
//   slave  : queue view (drives in_ready, write port, forwarding, count)
//   master : environment view (drives requests, drain_en, read indices)
interface mips_reg_writeback_queue_if
    import mips_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_reg;
    logic [DATA_W-1:0] in_data;
    logic              drain_en;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              signal_reg_write;
    logic [ADDR_W-1:0] read_reg_1;
    logic [ADDR_W-1:0] read_reg_2;
    logic              fwd_valid_1;
    logic [DATA_W-1:0] fwd_data_1;
    logic              fwd_valid_2;
    logic [DATA_W-1:0] fwd_data_2;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  in_valid, in_reg, in_data, drain_en, read_reg_1, read_reg_2,
        output in_ready, write_reg, write_data, signal_reg_write,
               fwd_valid_1, fwd_data_1, fwd_valid_2, fwd_data_2, count
    );

    modport master (
        output in_valid, in_reg, in_data, drain_en, read_reg_1, read_reg_2,
        input  in_ready, write_reg, write_data, signal_reg_write,
               fwd_valid_1, fwd_data_1, fwd_valid_2, fwd_data_2, count
    );
endinterface

// File: rtl/mips_wb_fwd_match.sv
// rtl/mips_wb_fwd_match.sv - youngest-match search over queued writebacks
// Purpose: combinational lookup of the newest queued write to i_read_reg.
//   i_regs / i_data : entry storage, indexed by physical slot
//   i_rd_ptr        : slot of the oldest live entry
//   i_count         : number of live entries
//   i_read_reg      : index being read; index 0 never matches
//   o_valid / o_data: a match exists / data of the youngest match
module mips_wb_fwd_match
    import mips_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic [ADDR_W-1:0]        i_regs [DEPTH],
    input  logic [DATA_W-1:0]        i_data [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] i_rd_ptr,
    input  logic [$clog2(DEPTH):0]   i_count,
    input  logic [ADDR_W-1:0]        i_read_reg,
    output logic                     o_valid,
    output logic [DATA_W-1:0]        o_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Walk from oldest to youngest; a later hit overrides an earlier one,
    // so the surviving match is the one nearest wr_ptr-1.
    always_comb begin
        o_valid = 1'b0;
        o_data  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < i_count) &&
                (i_read_reg != ADDR_W'(REG_ZERO)) &&
                (i_regs[i_rd_ptr + PTR_W'(i)] == i_read_reg)) begin
                o_valid = 1'b1;
                o_data  = i_data[i_rd_ptr + PTR_W'(i)];
            end
        end
    end
endmodule

// File: rtl/mips_reg_writeback_queue.sv
// rtl/mips_reg_writeback_queue.sv - in-order register-file writeback queue
// Purpose: buffers writeback requests and drains one per clock into the
// register file, with read-port forwarding of pending writes.
//   clk, rst_n : clock, asynchronous active-low reset
//   wb         : request handshake, write port, forwarding, count (slave)
module mips_reg_writeback_queue
    import mips_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input logic                       clk,
    input logic                       rst_n,
    mips_reg_writeback_queue_if.slave wb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_regs [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    // Register 0 completes the handshake but is never stored.
    assign w_push  = wb.in_valid && !w_full && (wb.in_reg != ADDR_W'(REG_ZERO));
    assign w_pop   = !w_empty && wb.drain_en;

    // in_ready looks only at registered occupancy, keeping drain_en off its path.
    assign wb.in_ready         = !w_full;
    assign wb.signal_reg_write = w_pop;
    assign wb.write_reg        = w_empty ? '0 : r_regs[r_rd_ptr];
    assign wb.write_data       = w_empty ? '0 : r_data[r_rd_ptr];
    assign wb.count            = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Entry payload needs no reset: slots outside the live window are
    // masked by r_count everywhere they are read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_regs[r_wr_ptr] <= wb.in_reg;
            r_data[r_wr_ptr] <= wb.in_data;
        end
    end

    mips_wb_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_1 (
        .i_regs     (r_regs),
        .i_data     (r_data),
        .i_rd_ptr   (r_rd_ptr),
        .i_count    (r_count),
        .i_read_reg (wb.read_reg_1),
        .o_valid    (wb.fwd_valid_1),
        .o_data     (wb.fwd_data_1)
    );

    mips_wb_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_2 (
        .i_regs     (r_regs),
        .i_data     (r_data),
        .i_rd_ptr   (r_rd_ptr),
        .i_count    (r_count),
        .i_read_reg (wb.read_reg_2),
        .o_valid    (wb.fwd_valid_2),
        .o_data     (wb.fwd_data_2)
    );
endmodule

// File: tb/tb_mips_reg_writeback_queue.sv
// tb/tb_mips_reg_writeback_queue.sv - self-checking bench for the writeback queue
module tb_mips_reg_writeback_queue;
    import mips_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    bit   cmp_en   = 0;

    wb_entry_t         mq[$];
    logic [36:0]       wr_log[$];

    mips_reg_writeback_queue_if #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) wb ();

    mips_reg_writeback_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .wb    (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference queue: plain FIFO of {reg, data}, advanced on each edge.
    always @(posedge clk) begin
        bit do_pop;
        bit do_push;
        if (rst_n) begin
            if (wb.signal_reg_write)
                wr_log.push_back({wb.write_reg, wb.write_data});
            do_pop  = (mq.size() != 0) && wb.drain_en;
            do_push = wb.in_valid && (mq.size() != DEPTH) && (wb.in_reg != 5'd0);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back('{reg_idx: wb.in_reg, data: wb.in_data});
        end else begin
            mq.delete();
        end
    end

    always @(negedge rst_n) mq.delete();

    function automatic logic [32:0] model_fwd(input logic [4:0] rr);
        if (rr == 5'd0) return 33'd0;
        for (int i = mq.size() - 1; i >= 0; i--)
            if (mq[i].reg_idx == rr) return {1'b1, mq[i].data};
        return 33'd0;
    endfunction

    always @(negedge clk) begin
        logic [32:0] f1;
        logic [32:0] f2;
        if (cmp_en) begin
            f1 = model_fwd(wb.read_reg_1);
            f2 = model_fwd(wb.read_reg_2);
            chk("m_count", wb.count, mq.size());
            chk("m_in_ready", wb.in_ready, mq.size() != DEPTH);
            chk("m_srw", wb.signal_reg_write, (mq.size() != 0) && wb.drain_en && rst_n);
            chk("m_write_reg", wb.write_reg, (mq.size() != 0) ? mq[0].reg_idx : 5'd0);
            chk("m_write_data", wb.write_data, (mq.size() != 0) ? mq[0].data : 32'd0);
            chk("m_fwd_valid_1", wb.fwd_valid_1, f1[32]);
            chk("m_fwd_data_1", wb.fwd_data_1, f1[31:0]);
            chk("m_fwd_valid_2", wb.fwd_valid_2, f2[32]);
            chk("m_fwd_data_2", wb.fwd_data_2, f2[31:0]);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [4:0] r, input logic [31:0] d);
        wb.in_valid = 1'b1;
        wb.in_reg   = r;
        wb.in_data  = d;
        step(1);
        wb.in_valid = 1'b0;
    endtask

    task automatic chk_log(input string name, input int idx, input logic [4:0] r, input logic [31:0] d);
        logic [36:0] e;
        if (idx < wr_log.size()) begin
            e = wr_log[idx];
            chk({name, "_reg"}, e[36:32], r);
            chk({name, "_data"}, e[31:0], d);
        end else begin
            chk({name, "_present"}, 0, 1);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        wb.in_valid    = 1'b0;
        wb.in_reg      = '0;
        wb.in_data     = '0;
        wb.drain_en    = 1'b0;
        wb.read_reg_1  = '0;
        wb.read_reg_2  = '0;
        step(1);
        cmp_en = 1;
        chk("rst_in_ready", wb.in_ready, 1);
        chk("rst_count", wb.count, 0);
        chk("rst_srw", wb.signal_reg_write, 0);
        chk("rst_write_reg", wb.write_reg, 0);
        chk("rst_fwd_valid_1", wb.fwd_valid_1, 0);
        step(1);
        rst_n = 1'b1;
        step(1);

        // 1: single push, forward, then drain
        wb.read_reg_1 = 5'd5;
        push(5'd5, 32'h0000_00AA);
        chk("t1_count", wb.count, 1);
        chk("t1_fwd_valid_1", wb.fwd_valid_1, 1);
        chk("t1_fwd_data_1", wb.fwd_data_1, 32'hAA);
        chk("t1_srw_idle", wb.signal_reg_write, 0);
        wr_log.delete();
        wb.drain_en = 1'b1;
        #1;
        chk("t1_srw_drain", wb.signal_reg_write, 1);
        step(1);
        wb.drain_en = 1'b0;
        chk("t1_count_after", wb.count, 0);
        chk("t1_log_size", wr_log.size(), 1);
        chk_log("t1_w0", 0, 5'd5, 32'hAA);

        // 2: duplicate destination, youngest forwards, in-order drain
        wr_log.delete();
        wb.read_reg_2 = 5'd7;
        push(5'd7, 32'd1);
        push(5'd7, 32'd2);
        push(5'd7, 32'd3);
        chk("t2_fwd_valid_2", wb.fwd_valid_2, 1);
        chk("t2_fwd_data_2", wb.fwd_data_2, 32'd3);
        wb.drain_en = 1'b1;
        step(3);
        wb.drain_en = 1'b0;
        chk("t2_log_size", wr_log.size(), 3);
        chk_log("t2_w0", 0, 5'd7, 32'd1);
        chk_log("t2_w1", 1, 5'd7, 32'd2);
        chk_log("t2_w2", 2, 5'd7, 32'd3);

        // 3: full, held request, wrap-around
        wr_log.delete();
        for (int k = 0; k < 4; k++) push(5'(k + 1), 32'h10 + k);
        wb.in_valid = 1'b1;
        wb.in_reg   = 5'd9;
        wb.in_data  = 32'h99;
        #1;
        chk("t3_full_ready", wb.in_ready, 0);
        step(1);
        chk("t3_held_count", wb.count, 4);
        wb.drain_en = 1'b1;
        step(1);
        wb.drain_en = 1'b0;
        chk("t3_ready_after_pop", wb.in_ready, 1);
        chk("t3_count_after_pop", wb.count, 3);
        step(1);
        wb.in_valid = 1'b0;
        chk("t3_count_refill", wb.count, 4);
        wb.drain_en = 1'b1;
        step(4);
        wb.drain_en = 1'b0;
        chk("t3_log_size", wr_log.size(), 5);
        chk_log("t3_w0", 0, 5'd1, 32'h10);
        chk_log("t3_w1", 1, 5'd2, 32'h11);
        chk_log("t3_w2", 2, 5'd3, 32'h12);
        chk_log("t3_w3", 3, 5'd4, 32'h13);
        chk_log("t3_w4", 4, 5'd9, 32'h99);

        // 4: register 0 is accepted but dropped
        wr_log.delete();
        wb.read_reg_1 = 5'd0;
        wb.in_valid   = 1'b1;
        wb.in_reg     = 5'd0;
        wb.in_data    = 32'hFFFF_FFFF;
        #1;
        chk("t4_ready", wb.in_ready, 1);
        step(1);
        wb.in_valid = 1'b0;
        chk("t4_count", wb.count, 0);
        chk("t4_fwd_valid_1", wb.fwd_valid_1, 0);
        wb.drain_en = 1'b1;
        step(2);
        wb.drain_en = 1'b0;
        chk("t4_no_writes", wr_log.size(), 0);

        // 5: steady push+pop at count 2
        wr_log.delete();
        wb.read_reg_1 = 5'd13;
        push(5'd11, 32'd1);
        push(5'd12, 32'd2);
        wb.drain_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wb.in_valid = 1'b1;
            wb.in_reg   = 5'(13 + k);
            wb.in_data  = 32'(100 + k);
            step(1);
            chk("t5_count", wb.count, 2);
        end
        wb.in_valid = 1'b0;
        step(2);
        wb.drain_en = 1'b0;
        chk("t5_log_size", wr_log.size(), 12);
        for (int k = 0; k < 12; k++) begin
            if (k < 2) chk_log("t5_w", k, 5'(11 + k), 32'(1 + k));
            else       chk_log("t5_w", k, 5'(13 + k - 2), 32'(100 + k - 2));
        end

        // 6: asynchronous reset mid-drain
        wr_log.delete();
        wb.read_reg_2 = 5'd21;
        push(5'd20, 32'hA0);
        push(5'd21, 32'hA1);
        push(5'd22, 32'hA2);
        chk("t6_count_pre", wb.count, 3);
        wb.drain_en = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_srw", wb.signal_reg_write, 0);
        chk("t6_write_reg", wb.write_reg, 0);
        chk("t6_write_data", wb.write_data, 0);
        chk("t6_count", wb.count, 0);
        chk("t6_fwd_valid_2", wb.fwd_valid_2, 0);
        chk("t6_fwd_data_2", wb.fwd_data_2, 0);
        chk("t6_in_ready", wb.in_ready, 1);
        step(2);
        rst_n = 1'b1;
        step(3);
        wb.drain_en = 1'b0;
        chk("t6_no_writes", wr_log.size(), 0);
        chk("t6_count_end", wb.count, 0);

        step(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
